// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending change dispenser.
package vend_pkg;

  typedef enum logic [1:0] {COIN_NONE, COIN_N, COIN_D, COIN_Q} coin_t;
  typedef enum logic [1:0] {IDLE, DISP, WAIT, FIN} disp_state_t;

  localparam int NICKEL_VAL  = 1;
  localparam int DIME_VAL    = 2;
  localparam int QUARTER_VAL = 5;

endpackage

// File: rtl/vend_change_disp_select.sv
// Greedy coin picker: largest coin that fits the remainder and is in stock.
module change_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 5,
  parameter int CNT_W = 4
) (
  input  logic [AMT_W-1:0] i_rem,
  input  logic [CNT_W-1:0] i_q_cnt,
  input  logic [CNT_W-1:0] i_d_cnt,
  input  logic [CNT_W-1:0] i_n_cnt,
  output coin_t            o_choice,
  output logic [AMT_W-1:0] o_val
);

  localparam logic [AMT_W-1:0] LP_Q = AMT_W'(QUARTER_VAL);
  localparam logic [AMT_W-1:0] LP_D = AMT_W'(DIME_VAL);
  localparam logic [AMT_W-1:0] LP_N = AMT_W'(NICKEL_VAL);

  always_comb begin
    o_choice = COIN_NONE;
    o_val    = '0;
    if (i_rem >= LP_Q && i_q_cnt != '0) begin
      o_choice = COIN_Q;
      o_val    = LP_Q;
    end else if (i_rem >= LP_D && i_d_cnt != '0) begin
      o_choice = COIN_D;
      o_val    = LP_D;
    end else if (i_rem >= LP_N && i_n_cnt != '0) begin
      o_choice = COIN_N;
      o_val    = LP_N;
    end
  end

endmodule

// File: rtl/vend_change_disp.sv
// Change dispenser: pays out an amount in nickels as spaced N/D/Q pulses,
// limited by per-coin stock, and reports completion with any shortfall.
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int AMT_W      = 5,
  parameter int CNT_W      = 4,
  parameter int STOCK_INIT = 8,
  parameter int GAP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic             restock,
  output logic             ready,
  output logic             N,
  output logic             D,
  output logic             Q,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] rem_out,
  output logic [CNT_W-1:0] n_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] q_cnt
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] LP_STOCK = CNT_W'(STOCK_INIT);
  localparam logic [GW-1:0]    LP_GAP   = GW'(GAP - 1);

  disp_state_t      r_state, w_state_nxt;
  logic [AMT_W-1:0] r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_n_cnt, r_d_cnt, r_q_cnt;
  logic [GW-1:0]    r_gap;
  logic             r_n, r_d, r_q, r_done, r_short;
  logic [AMT_W-1:0] r_rem_out;
  coin_t            w_choice;
  logic [AMT_W-1:0] w_val;
  logic             w_coin;
  logic             w_restock;

  change_select #(
    .AMT_W(AMT_W),
    .CNT_W(CNT_W)
  ) u_select (
    .i_rem   (r_rem),
    .i_q_cnt (r_q_cnt),
    .i_d_cnt (r_d_cnt),
    .i_n_cnt (r_n_cnt),
    .o_choice(w_choice),
    .o_val   (w_val)
  );

  assign w_coin    = (r_state == DISP) && (w_choice != COIN_NONE);
  assign w_restock = (r_state == IDLE) && restock;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (amt != '0) ? DISP : FIN;
          w_rem_nxt   = amt;
        end
      end
      DISP: begin
        if (w_coin) begin
          w_state_nxt = WAIT;
          w_rem_nxt   = r_rem - w_val;
        end else begin
          w_state_nxt = FIN;
        end
      end
      WAIT: begin
        if (r_gap == '0) w_state_nxt = (r_rem == '0) ? FIN : DISP;
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (r_state == DISP)     r_gap <= LP_GAP;
      else if (r_gap != '0)    r_gap <= r_gap - GW'(1);
    end
  end

  // Restock wins over nothing else: a coin can only be taken in DISP, never in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n_cnt <= LP_STOCK;
      r_d_cnt <= LP_STOCK;
      r_q_cnt <= LP_STOCK;
    end else if (w_restock) begin
      r_n_cnt <= LP_STOCK;
      r_d_cnt <= LP_STOCK;
      r_q_cnt <= LP_STOCK;
    end else if (w_coin) begin
      case (w_choice)
        COIN_Q:  r_q_cnt <= r_q_cnt - CNT_W'(1);
        COIN_D:  r_d_cnt <= r_d_cnt - CNT_W'(1);
        COIN_N:  r_n_cnt <= r_n_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n       <= 1'b0;
      r_d       <= 1'b0;
      r_q       <= 1'b0;
      r_done    <= 1'b0;
      r_short   <= 1'b0;
      r_rem_out <= '0;
    end else begin
      r_n    <= w_coin && (w_choice == COIN_N);
      r_d    <= w_coin && (w_choice == COIN_D);
      r_q    <= w_coin && (w_choice == COIN_Q);
      r_done <= (w_state_nxt == FIN);
      // Result is latched on entry to FIN and held until the next job ends.
      if (w_state_nxt == FIN) begin
        r_short   <= (w_rem_nxt != '0);
        r_rem_out <= w_rem_nxt;
      end
    end
  end

  assign ready   = (r_state == IDLE);
  assign N       = r_n;
  assign D       = r_d;
  assign Q       = r_q;
  assign done    = r_done;
  assign short   = r_short;
  assign rem_out = r_rem_out;
  assign n_cnt   = r_n_cnt;
  assign d_cnt   = r_d_cnt;
  assign q_cnt   = r_q_cnt;

endmodule

// File: tb/tb_vend_change_disp.sv
// Scoreboard bench for vend_change_disp: two instances (stock 8 and stock 1).
module tb_vend_change_disp;

  localparam int AMT_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sel = 1'b0;
  logic             start = 1'b0;
  logic             restock = 1'b0;
  logic [AMT_W-1:0] amt = '0;

  logic             rdy8, n8, d8, q8, done8, sh8;
  logic [AMT_W-1:0] rem8;
  logic [CNT_W-1:0] nc8, dc8, qc8;
  logic             rdy1, n1, d1, q1, done1, sh1;
  logic [AMT_W-1:0] rem1;
  logic [CNT_W-1:0] nc1, dc1, qc1;

  logic             m_ready, m_N, m_D, m_Q, m_done, m_short;
  logic [AMT_W-1:0] m_rem_out;
  logic [CNT_W-1:0] m_n_cnt, m_d_cnt, m_q_cnt;

  vend_change_disp #(.AMT_W(AMT_W), .CNT_W(CNT_W), .STOCK_INIT(8), .GAP(1)) u_dut8 (
    .clk(clk), .reset(rst_n), .start(start & ~sel), .amt(amt), .restock(restock & ~sel),
    .ready(rdy8), .N(n8), .D(d8), .Q(q8), .done(done8), .short(sh8), .rem_out(rem8),
    .n_cnt(nc8), .d_cnt(dc8), .q_cnt(qc8)
  );

  vend_change_disp #(.AMT_W(AMT_W), .CNT_W(CNT_W), .STOCK_INIT(1), .GAP(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start & sel), .amt(amt), .restock(restock & sel),
    .ready(rdy1), .N(n1), .D(d1), .Q(q1), .done(done1), .short(sh1), .rem_out(rem1),
    .n_cnt(nc1), .d_cnt(dc1), .q_cnt(qc1)
  );

  assign m_ready   = sel ? rdy1  : rdy8;
  assign m_N       = sel ? n1    : n8;
  assign m_D       = sel ? d1    : d8;
  assign m_Q       = sel ? q1    : q8;
  assign m_done    = sel ? done1 : done8;
  assign m_short   = sel ? sh1   : sh8;
  assign m_rem_out = sel ? rem1  : rem8;
  assign m_n_cnt   = sel ? nc1   : nc8;
  assign m_d_cnt   = sel ? dc1   : dc8;
  assign m_q_cnt   = sel ? qc1   : qc8;

  always #5 clk = ~clk;

  // kind: 1=N 2=D 3=Q 4=done
  typedef struct {
    int kind;
    int cyc;
    int sh;
    int rem;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  mn[2];
  int  md[2];
  int  mq[2];
  int  si[2] = '{8, 1};
  int  mon_kind;
  ev_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_cnt(input int n, input int d, input int q);
    chk("n_cnt", int'(m_n_cnt), n);
    chk("d_cnt", int'(m_d_cnt), d);
    chk("q_cnt", int'(m_q_cnt), q);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mn[s] = si[s];
      md[s] = si[s];
      mq[s] = si[s];
    end
  endtask

  // Greedy reference: start sampled at edge k+1, coins seen at k+2, k+4, ...
  task automatic push_job(input int s, input int a, input int k);
    int  rem;
    int  c;
    int  kind;
    int  dcyc;
    bit  stop;
    ev_t e;
    rem  = a;
    c    = 0;
    stop = 1'b0;
    for (int i = 0; i < 64 && !stop; i++) begin
      kind = 0;
      if (rem >= 5 && mq[s] > 0) begin kind = 3; mq[s]--; rem -= 5; end
      else if (rem >= 2 && md[s] > 0) begin kind = 2; md[s]--; rem -= 2; end
      else if (rem >= 1 && mn[s] > 0) begin kind = 1; mn[s]--; rem -= 1; end
      if (kind == 0) stop = 1'b1;
      else begin
        e = '{kind, k + 2 + 2 * c, 0, 0};
        exp_q.push_back(e);
        c++;
      end
    end
    if (a == 0)        dcyc = k + 1;
    else if (rem == 0) dcyc = k + 2 * c + 1;
    else               dcyc = k + 2 * c + 2;
    e = '{4, dcyc, (rem != 0) ? 1 : 0, rem};
    exp_q.push_back(e);
  endtask

  task automatic run_job(input int a, input bit rs, input bit poke);
    int k;
    int s;
    s = sel ? 1 : 0;
    @(posedge clk); #1;
    start   = 1'b1;
    amt     = AMT_W'(a);
    restock = rs;
    k       = cyc;
    if (rs) begin mn[s] = si[s]; md[s] = si[s]; mq[s] = si[s]; end
    push_job(s, a, k);
    @(posedge clk); #1;
    start   = 1'b0;
    restock = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      start   = 1'b1;
      amt     = AMT_W'(3);
      restock = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      restock = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      chk("timeout_pending_events", exp_q.size(), 0);
      exp_q.delete();
    end
    #1;
    chk("ready_after_done", int'(m_ready), 1);
  endtask

  always @(negedge clk) begin
    if (rst_n && (m_N || m_D || m_Q || m_done)) begin
      if ($countones({m_N, m_D, m_Q}) > 1) chk("onehot_coin", $countones({m_N, m_D, m_Q}), 1);
      mon_kind = m_Q ? 3 : m_D ? 2 : m_N ? 1 : 4;
      if (exp_q.size() == 0) chk("unexpected_event", mon_kind, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", mon_kind, mon_e.kind);
        chk("event_cycle", cyc, mon_e.cyc);
        if (mon_kind == 4) begin
          chk("short", int'(m_short), mon_e.sh);
          chk("rem_out", int'(m_rem_out), mon_e.rem);
          chk("ready_at_done", int'(m_ready), 0);
        end
      end
    end
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(m_ready), 1);
    chk("rst_N", int'(m_N), 0);
    chk("rst_D", int'(m_D), 0);
    chk("rst_Q", int'(m_Q), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_short", int'(m_short), 0);
    chk("rst_rem_out", int'(m_rem_out), 0);
    chk_cnt(8, 8, 8);
    rst_n = 1'b1;
    model_reset();

    run_job(7, 1'b0, 1'b0);
    chk_cnt(8, 7, 7);

    run_job(0, 1'b0, 1'b0);
    chk_cnt(8, 7, 7);

    @(posedge clk); #1;
    restock = 1'b1;
    mn[0] = 8; md[0] = 8; mq[0] = 8;
    @(posedge clk); #1;
    restock = 1'b0;
    chk_cnt(8, 8, 8);

    run_job(7, 1'b0, 1'b1);
    chk_cnt(8, 7, 7);

    // Abort a job during the WAIT cycle following the first quarter.
    @(posedge clk); #1;
    start = 1'b1;
    amt   = AMT_W'(7);
    k     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_q_pulse", int'(m_Q), 1);
    chk("abort_q_cycle", cyc, k + 2);
    rst_n = 1'b0;
    #1;
    chk("abort_N", int'(m_N), 0);
    chk("abort_D", int'(m_D), 0);
    chk("abort_Q", int'(m_Q), 0);
    chk("abort_done", int'(m_done), 0);
    chk_cnt(8, 8, 8);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("abort_ready", int'(m_ready), 1);
    repeat (8) @(posedge clk);
    #1;

    sel = 1'b1;
    #1;
    chk_cnt(1, 1, 1);
    run_job(12, 1'b0, 1'b0);
    chk_cnt(0, 0, 0);

    run_job(5, 1'b1, 1'b0);
    chk_cnt(1, 1, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("leftover_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_change_disp.md
Name: vend_change_disp

Overview:
- Change dispenser for the vending datapath: the outbound counterpart of the coin-accept (N/D/Q) interface.
- Accepts a change amount in nickels with a start handshake, then emits one-cycle N/D/Q coin pulses, greedy largest-coin-first, limited by per-coin stock counters.
- Reports completion, plus shortfall when exact change is impossible.
- Sits between the vend controller and the coin-return solenoids.

Parameters:
AMT_W, 5, width of amount in nickels (max 31 = $1.55)
CNT_W, 4, width of each stock counter
STOCK_INIT, 8, stock value loaded per coin type on reset/restock (must be < 2**CNT_W)
GAP, 1, cycles spent in WAIT after each coin pulse (>=1); pulses are GAP+1 cycles apart

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready=1
amt  input  AMT_W  change owed in nickels, sampled with start
restock  input  1  reload all stock counters to STOCK_INIT; honoured only in IDLE
ready  output  1  high in IDLE only
N  output  1  one-cycle nickel dispense pulse
D  output  1  one-cycle dime dispense pulse
Q  output  1  one-cycle quarter dispense pulse
done  output  1  one-cycle completion pulse
short  output  1  valid with done: 1 = amount not fully dispensed
rem_out  output  AMT_W  valid with done: undispensed nickels
n_cnt, d_cnt, q_cnt  output  CNT_W each  current stock

Behaviour:
- Reset (reset=0, async):
  - state IDLE, rem=0, N=D=Q=0, done=0, short=0, rem_out=0.
  - all stock = STOCK_INIT.
  - Mid-operation reset aborts the job; no done is issued.
- FSM states: IDLE, DISP, WAIT, FIN.
- IDLE (ready=1):
  - start & amt!=0 -> DISP, rem<=amt.
  - start & amt==0 -> FIN, rem<=0.
  - restock -> all stock<=STOCK_INIT.
  - start and restock on the same edge: both apply, and the job uses the reloaded stock.
- DISP: coin choice is combinational, first match wins:
  - rem>=5 & q_cnt>0 -> Q
  - else rem>=2 & d_cnt>0 -> D
  - else rem>=1 & n_cnt>0 -> N
  - else none
  - On a coin: the registered pulse is high for exactly one cycle, starting the cycle after the DISP edge. On that edge rem decrements by the coin value (5/2/1) and the chosen stock decrements by 1. Next state is WAIT.
  - No coin possible -> FIN, no pulse.
- WAIT:
  - Lasts GAP cycles; the coin pulse coincides with the first WAIT cycle.
  - Exit: rem==0 -> FIN, else -> DISP.
- FIN:
  - done=1 for one cycle, ready=0.
  - short=(rem!=0), rem_out=rem.
  - Next state IDLE.
- At most one of N/D/Q is high in any cycle. N/D/Q/done/short/rem_out are all registered.
- Latency with GAP=1: start at edge E0 -> first pulse in the cycle after E1. Each coin costs 2 cycles. done is high the cycle after the last WAIT edge.
- Ignored inputs:
  - start while ready=0 is ignored (no queuing).
  - restock outside IDLE is ignored.
- Stock never underflows (guarded by the >0 checks). Rem never underflows (guarded by the >= checks).
- short/rem_out hold their value until the next done. They are meaningful only while done=1.

Decomposition:
- vend_pkg: coin_t enum {COIN_NONE, COIN_N, COIN_D, COIN_Q}; localparams NICKEL_VAL=1, DIME_VAL=2, QUARTER_VAL=5; disp_state_t enum {IDLE, DISP, WAIT, FIN}.
- Sub-module change_select (combinational): inputs rem, q_cnt, d_cnt, n_cnt; outputs coin_t choice and coin value.
- Top level holds the FSM, rem register, GAP counter, stock counters and output registers.

Test Plan:
- Reset, STOCK_INIT=8, start amt=7 -> Q pulse then D pulse, 2 cycles apart; done with short=0, rem_out=0; q_cnt=7, d_cnt=7, n_cnt=8; ready returns the cycle after done.
- start amt=0 -> no N/D/Q; done on the 2nd cycle after start, short=0, rem_out=0.
- STOCK_INIT=1, amt=12 -> Q(rem 7), D(rem 5), N(rem 4), then no coin; done with short=1, rem_out=4; all counts 0.
- During the case-1 job, pulse start (amt=3) and restock mid-job -> both ignored; only Q, D observed; counts 7/7/8 after done.
- Reset asserted in the WAIT cycle after the first Q -> N/D/Q/done drop to 0 asynchronously; counts return to 8; no done; ready=1 after release.
- After depleting stock as in case 3, assert restock and start amt=5 on the same IDLE edge -> single Q pulse; done with short=0; q_cnt=STOCK_INIT-1.
